// File: rtl/compare_seq.sv
// Sequential magnitude comparator: walks WIDTH-bit operands one CHUNK-bit slice
// per clock, MSB slice first, and stops on the first differing slice.
module compare_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             busy,
    output logic             done,
    output logic             QAGB,
    output logic             QASB,
    output logic             QAEB
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SH_W  = $clog2(WIDTH) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CMP  = 1'b1;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_agb;
    logic             r_asb;
    logic             r_aeb;

    logic [SH_W-1:0]  w_shamt;
    logic [CHUNK-1:0] w_slice_a;
    logic [CHUNK-1:0] w_slice_b;
    logic             w_differ;
    logic             w_a_gt;

    // Shift the current slice up to the top, then bring it down to bit 0.
    assign w_shamt   = SH_W'(r_idx) * SH_W'(CHUNK);
    assign w_slice_a = CHUNK'((r_a << w_shamt) >> (WIDTH - CHUNK));
    assign w_slice_b = CHUNK'((r_b << w_shamt) >> (WIDTH - CHUNK));
    assign w_differ  = (w_slice_a != w_slice_b);
    assign w_a_gt    = (w_slice_a > w_slice_b);

    // Control FSM, operand latches and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_agb   <= 1'b0;
            r_asb   <= 1'b0;
            r_aeb   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Offset-binary: flipping both MSBs turns signed order into unsigned order.
                        r_a     <= signed_mode ? (DataA ^ MSB_MASK) : DataA;
                        r_b     <= signed_mode ? (DataB ^ MSB_MASK) : DataB;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_agb   <= 1'b0;
                        r_asb   <= 1'b0;
                        r_aeb   <= 1'b0;
                        r_state <= S_CMP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CMP: begin
                    if (w_differ) begin
                        r_agb   <= w_a_gt;
                        r_asb   <= ~w_a_gt;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_idx == LAST_IDX) begin
                        r_aeb   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign QAGB = r_agb;
    assign QASB = r_asb;
    assign QAEB = r_aeb;

endmodule

// File: tb/tb_compare_seq.sv
// Scoreboard bench for compare_seq: expected flags and latency are queued at
// start and checked when done pulses.
module tb_compare_seq;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NS    = WIDTH / CHUNK;

    typedef struct packed {
        logic       gt;
        logic       lt;
        logic       eq;
        logic [7:0] lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             signed_mode = 1'b0;
    logic [WIDTH-1:0] DataA = '0;
    logic [WIDTH-1:0] DataB = '0;
    logic             busy, done, QAGB, QASB, QAEB;

    exp_t sb[$];
    logic [2:0] last_flags = 3'b000;
    int n_vec = 0;
    int n_err = 0;

    compare_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .DataA(DataA), .DataB(DataB), .busy(busy), .done(done),
        .QAGB(QAGB), .QASB(QASB), .QAEB(QAEB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm);
        exp_t e;
        logic [CHUNK-1:0] sa, sb_s;
        bit found;
        if (sm) begin
            e.gt = ($signed(a) > $signed(b));
            e.lt = ($signed(a) < $signed(b));
        end else begin
            e.gt = (a > b);
            e.lt = (a < b);
        end
        e.eq  = (a == b);
        e.lat = 8'(NS);
        found = 1'b0;
        for (int i = 0; i < NS; i++) begin
            sa   = CHUNK'(a >> (WIDTH - CHUNK * (i + 1)));
            sb_s = CHUNK'(b >> (WIDTH - CHUNK * (i + 1)));
            if (!found && sa != sb_s) begin
                found = 1'b1;
                e.lat = 8'(i + 1);
            end
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm);
        DataA = a;
        DataB = b;
        signed_mode = sm;
        start = 1'b1;
        sb.push_back(model(a, b, sm));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        DataA = WIDTH'($urandom);
        DataB = WIDTH'($urandom);
        signed_mode = 1'($urandom);
        chk("busy_start", {31'd0, busy}, 32'd1);
    endtask

    // Waits for done at negedges; optionally pokes start at cycle 'poke'.
    task automatic wait_done(input int poke);
        exp_t e;
        int cyc;
        bit seen;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 2 * NS + 4) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("latency", cyc, 32'(e.lat));
                    chk("QAGB", {31'd0, QAGB}, {31'd0, e.gt});
                    chk("QASB", {31'd0, QASB}, {31'd0, e.lt});
                    chk("QAEB", {31'd0, QAEB}, {31'd0, e.eq});
                    chk("busy_done", {31'd0, busy}, 32'd0);
                    last_flags = {e.gt, e.lt, e.eq};
                end else begin
                    chk("unexpected_done", {31'd0, done}, 32'd0);
                end
            end else begin
                chk("busy_run", {31'd0, busy}, 32'd1);
                chk("flags_run", {29'd0, QAGB, QASB, QAEB}, 32'd0);
                if (cyc == poke) begin
                    start = 1'b1;
                    DataA = 16'hFFFF;
                    DataB = 16'h0000;
                    signed_mode = 1'b0;
                end
            end
        end
        if (!seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk("timeout_lat", cyc, 32'(e.lat));
        end
    endtask

    task automatic idle_chk();
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("flags_hold", {29'd0, QAGB, QASB, QAEB}, {29'd0, last_flags});
    endtask

    initial begin
        logic [WIDTH-1:0] wa, wb;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_low", {27'd0, busy, done, QAGB, QASB, QAEB}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel", {27'd0, busy, done, QAGB, QASB, QAEB}, 32'd0);

        do_cmp(16'h8000, 16'h0001, 1'b0); wait_done(-1); idle_chk();
        do_cmp(16'h0001, 16'h8000, 1'b0); wait_done(-1); idle_chk();
        do_cmp(16'h1234, 16'h1235, 1'b0); wait_done(-1); idle_chk();

        // Back-to-back: second start issued in the done cycle.
        do_cmp(16'hABCD, 16'hABCD, 1'b0); wait_done(-1);
        do_cmp(16'h0100, 16'h00FF, 1'b0); wait_done(-1); idle_chk();

        do_cmp(16'h8000, 16'h0001, 1'b1); wait_done(-1); idle_chk();
        do_cmp(16'hFFFF, 16'hFFFE, 1'b1); wait_done(-1); idle_chk();

        wa = 16'h0001;
        wb = 16'h8000;
        for (int i = 0; i < WIDTH; i++) begin
            do_cmp(wa, wb, 1'b0); wait_done(-1);
            wa = wa << 1;
            wb = wb >> 1;
        end
        idle_chk();

        do_cmp(16'h1111, 16'h1112, 1'b0); wait_done(1); idle_chk();

        // Asynchronous reset between edges clears held flags at once.
        do_cmp(16'h0F00, 16'h0E00, 1'b0); wait_done(-1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {27'd0, busy, done, QAGB, QASB, QAEB}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset dropped mid-compare: no done, then normal operation.
        do_cmp(16'h0000, 16'h0001, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("abort_rst", {27'd0, busy, done, QAGB, QASB, QAEB}, 32'd0);
        sb.delete();
        repeat (2) begin
            @(negedge clk);
            chk("abort_nodone", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (NS) begin
            @(negedge clk);
            chk("abort_idle", {27'd0, busy, done, QAGB, QASB, QAEB}, 32'd0);
        end
        do_cmp(16'h7FFF, 16'h8000, 1'b1); wait_done(-1); idle_chk();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/compare_seq.md
# compare_seq

Parametrised sequential magnitude comparator, successor to the two-half combinational `compare_8`. It compares two WIDTH-bit operands one CHUNK-bit slice per clock, most significant slice first, and terminates early on the first differing slice. It supports unsigned and two's-complement modes selected per operation. Results come back through a start/done handshake. It sits wherever wide operands must be ordered without a full-width combinational compare path.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK, at least CHUNK.
- CHUNK, 4, bits compared per cycle; the number of slices is N = WIDTH/CHUNK.
- clk  input  1  clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a compare; sampled only while idle.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- DataA  input  WIDTH  operand A; sampled with start.
- DataB  input  WIDTH  operand B; sampled with start.
- busy  output  1  comparison in progress.
- done  output  1  one-cycle pulse; the flags are valid from this cycle on.
- QAGB  output  1  A > B.
- QASB  output  1  A < B.
- QAEB  output  1  A == B.

## Operation
- FSM states:
  - IDLE: accepts start.
  - CMP: one slice compared per cycle.
- On reset, whether asynchronous assertion or mid-operation:
  - state = IDLE; slice index = 0.
  - busy, done, QAGB, QASB and QAEB are all 0.
  - Operand registers are cleared; any comparison in progress is abandoned with no done.
- IDLE with start=1 at a rising edge:
  - Latch DataA, DataB and signed_mode into internal registers.
  - Index = 0 (the most significant slice), busy = 1, go to CMP.
  - Clear QAGB/QASB/QAEB to 0 for the duration of the comparison.
- Signed mode: the operand MSB is inverted in both latched copies before comparing. This offset-binary trick makes an unsigned slice compare give the signed order.
- Each CMP cycle compares slice [WIDTH-1-CHUNK*idx -: CHUNK] of A against the same slice of B, unsigned:
  - Slices differ: set QAGB or QASB accordingly, pulse done, busy = 0, go to IDLE.
  - Slices equal and idx = N-1: set QAEB, pulse done, busy = 0, go to IDLE.
  - Slices equal otherwise: idx+1, stay in CMP.
- After a comparison, exactly one of QAGB/QASB/QAEB is 1. The flags hold until the next accepted start or until reset.
- start while busy=1 is ignored. No queuing and no effect on the operation in flight.
- DataA/DataB/signed_mode changes while busy have no effect.

## Timing
- start accepted at edge T0; busy is high after T0.
- If the first differing slice is index k, done and the flags appear after edge T0+k+1. Latency is k+1 cycles, minimum 1.
- Equal operands: latency N cycles, which is the maximum.
- done is high for exactly one cycle. busy falls on the same edge at which done rises.
- start asserted in the cycle done is high is accepted, since the block is already IDLE. This gives back-to-back operation with no bubble cycle.
- All outputs are registered; there is no combinational path from the inputs to the outputs.

## Test plan
Defaults WIDTH=16, CHUNK=4.
- Reset: rst_n low for 2 cycles, then high -> busy=done=QAGB=QASB=QAEB=0. Assert rst_n low asynchronously between edges -> outputs clear immediately.
- Unsigned, early exit: A=0x8000, B=0x0001, signed_mode=0 -> QAGB=1 and done after 1 cycle. Swapped operands -> QASB=1 after 1 cycle.
- Late difference: A=0x1234, B=0x1235 -> QASB=1 and done exactly 4 cycles after start; busy is high for 4 cycles.
- Equal and back-to-back: A=B=0xABCD -> QAEB=1 after 4 cycles. Then start again in the done cycle with A=0x0100, B=0x00FF -> QAGB=1 after 2 more cycles.
- Signed vs unsigned, walking bits: A=0x8000 (-32768), B=0x0001, signed_mode=1 -> QASB=1 after 1 cycle. Then A=0xFFFF, B=0xFFFE, signed -> QAGB=1 after 4 cycles. Then walk a single one: A<<=1, B>>=1 each run from A=0x0001, B=0x8000 unsigned -> the flags follow the integer order on every step.
- Abuse:
  - start pulsed while busy on A=0x1111, B=0x1112 -> ignored; the original result QASB is returned at cycle 4.
  - rst_n dropped at cycle 2 of a compare -> no done; all flags are 0; a new start afterwards works normally.
